// File: rtl/nexi_uart_pkg.sv
// Shared constants and handshake state encoding for the UART receive path.
package nexi_uart_pkg;

  localparam int UART_DW       = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_hs_state_e;

endpackage

// File: rtl/nexi_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module nexi_sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nexi_uart_rx_fifo.sv
// UART receive FIFO: drains the receiver's four-phase handshake into a FWFT FIFO.
// Optional level-threshold interrupt enabled by NEXI_UART_RX_FIFO_THRESH_IRQ_EN.
module nexi_uart_rx_fifo
  import nexi_uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
  , parameter int THRESH = DEPTH / 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [UART_DW-1:0] rx_data,
  input  logic               rx_data_ready,
  output logic               rx_read_ack,
  input  logic               rd_en,
  output logic [UART_DW-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        level,
  output logic               overrun,
  input  logic               ovr_clr
`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
  , output logic             irq_thresh
`endif
);

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Receiver side is a four-phase level handshake: ready rises with a stable
  // byte, ack rises once the byte is taken, ready falls, then ack falls.
  logic rdy_s;

  nexi_sync_2ff #(.W(1)) u_rdy_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx_data_ready),
    .q_o   (rdy_s)
  );

  rx_hs_state_e       state_q;
  logic               ack_q;
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [AW:0]        level_q;
  logic [AW:0]        level_d;
  logic               full_q;
  logic               empty_q;
  logic               ovr_q;
  logic [UART_DW-1:0] mem_q [DEPTH];

  logic take;
  logic do_pop;
  logic do_push;
  logic drop;

  always_comb begin
    take    = (state_q == ST_IDLE) && rdy_s;
    do_pop  = rd_en && !empty_q;
    // A pop in the same cycle frees the slot the incoming byte needs.
    do_push = take && (!full_q || do_pop);
    drop    = take && !do_push;
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_ONE;
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (rdy_s) begin
        state_q <= ST_ACK;
        ack_q   <= 1'b1;
      end
    end else begin
      if (!rdy_s) begin
        state_q <= ST_IDLE;
        ack_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= rx_data;
    end
  end

`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
  localparam logic [AW:0] LVL_THRESH = (AW+1)'(THRESH);

  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (level_d >= LVL_THRESH);
    end
  end

  assign irq_thresh = irq_q;
`endif

  assign rx_read_ack = ack_q;
  assign rd_data     = mem_q[rptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign level       = level_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_nexi_uart_rx_fifo.sv
// Bench for nexi_uart_rx_fifo: scenario tasks against a queue-based FIFO model.
module tb_nexi_uart_rx_fifo;
  import nexi_uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_data_ready;
  logic         rx_read_ack;
  logic         rd_en;
  logic [7:0]   rd_data;
  logic         empty;
  logic         full;
  logic [AW:0]  level;
  logic         overrun;
  logic         ovr_clr;
`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
  logic         irq_thresh;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       ovr_m;

  always #5 clk = ~clk;

  nexi_uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .rx_read_ack   (rx_read_ack),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .overrun       (overrun),
    .ovr_clr       (ovr_clr)
`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
    , .irq_thresh  (irq_thresh)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Model: a completed handshake stores the byte if there is room, else flags overrun.
  task automatic model_accept(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic wait_ack(input logic want, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (rx_read_ack !== want && n < 12);
    vectors++;
    if (rx_read_ack !== want || n != 3) begin
      miscompares++;
      $display("FAIL %s: ack=%b after %0d edges, required %b after 3", name, rx_read_ack, n, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data       = b;
    rx_data_ready = 1'b1;
    wait_ack(1'b1, "ack_rise");
    model_accept(b);
    rx_data_ready = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic pop_byte();
    @(negedge clk);
    vectors++;
    if (exp_q.size() == 0) begin
      if (empty !== 1'b1) begin
        miscompares++;
        $display("FAIL pop_empty: empty=%b, required 1", empty);
      end
    end else if (empty !== 1'b0 || rd_data !== exp_q[0]) begin
      miscompares++;
      $display("FAIL pop_data: empty=%b rd_data=%h, required 0 and %h", empty, rd_data, exp_q[0]);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // Handshake whose push edge coincides with a pop and/or an overrun clear.
  task automatic send_timed(input logic [7:0] b, input logic pop, input logic clr);
    logic [7:0] head;
    @(negedge clk);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    vectors++;
    if (pop && rd_data !== head) begin
      miscompares++;
      $display("FAIL timed_head: rd_data=%h, required %h", rd_data, head);
    end
    rd_en   = pop;
    ovr_clr = clr;
    @(posedge clk); #1;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
    vectors++;
    if (rx_read_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL timed_ack: ack=%b, required 1", rx_read_ack);
    end
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() >= DEPTH) ovr_m = 1'b1;
    else begin
      exp_q.push_back(b);
      if (clr) ovr_m = 1'b0;
    end
    rx_data_ready = 1'b0;
    wait_ack(1'b0, "timed_ack_fall");
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = 8'h00; rx_data_ready = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    exp_q.delete(); ovr_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (rx_read_ack !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || level !== '0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: ack=%b empty=%b full=%b level=%0d ovr=%b, required 0 1 0 0 0",
               rx_read_ack, empty, full, level, overrun);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    send_byte(8'hA5);
    @(negedge clk);
    vectors++;
    if (empty !== 1'b0 || level !== (AW+1)'(1) || rd_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single: empty=%b level=%0d rd_data=%h, required 0 1 a5", empty, level, rd_data);
    end
    pop_byte();
    vectors++;
    if (empty !== 1'b1 || level !== '0) begin
      miscompares++;
      $display("FAIL single_pop: empty=%b level=%0d, required 1 0", empty, level);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
    vectors++;
    if (full !== 1'b1 || level !== (AW+1)'(DEPTH) || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL fill: full=%b level=%0d ovr=%b, required 1 %0d 0", full, level, overrun, DEPTH);
    end
    send_byte(8'hFF);
    vectors++;
    if (overrun !== ovr_m || ovr_m !== 1'b1 || level !== (AW+1)'(DEPTH)) begin
      miscompares++;
      $display("FAIL fill_drop: ovr=%b level=%0d, required 1 %0d", overrun, level, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) pop_byte();
  endtask

  task automatic test_ovr_clr();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0; ovr_m = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clr: ovr=%b, required 0", overrun);
    end
    send_timed(8'h5A, 1'b0, 1'b1);
    vectors++;
    if (overrun !== 1'b1 || level !== (AW+1)'(DEPTH)) begin
      miscompares++;
      $display("FAIL ovr_set_wins: ovr=%b level=%0d, required 1 %0d", overrun, level, DEPTH);
    end
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0; ovr_m = 1'b0;
  endtask

  task automatic test_full_simul();
    send_timed(8'hC3, 1'b1, 1'b0);
    vectors++;
    if (overrun !== 1'b0 || level !== (AW+1)'(DEPTH) || full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_simul: ovr=%b level=%0d full=%b, required 0 %0d 1", overrun, level, full, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) pop_byte();
  endtask

  task automatic test_underflow_wrap();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    vectors++;
    if (level !== '0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow: level=%0d empty=%b, required 0 1", level, empty);
    end
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      pop_byte();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: send_byte(8'($urandom_range(0, 255)));
        3: pop_byte();
        default: begin
          @(negedge clk); ovr_clr = 1'b1;
          @(negedge clk); ovr_clr = 1'b0; ovr_m = 1'b0;
        end
      endcase
      vectors++;
      if (level !== (AW+1)'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
          empty !== (exp_q.size() == 0) || overrun !== ovr_m) begin
        miscompares++;
        $display("FAIL random[%0d]: level=%0d full=%b empty=%b ovr=%b, required %0d %b %b %b",
                 i, level, full, empty, overrun, exp_q.size(), exp_q.size() == DEPTH,
                 exp_q.size() == 0, ovr_m);
      end
    end
    while (exp_q.size() > 0) pop_byte();
  endtask

  task automatic test_reset_in_ack();
    send_byte(8'h11);
    @(negedge clk);
    rx_data       = 8'h3C;
    rx_data_ready = 1'b1;
    wait_ack(1'b1, "rst_ack_rise");
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); ovr_m = 1'b0;
    vectors++;
    if (rx_read_ack !== 1'b0 || level !== '0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_in_ack: ack=%b level=%0d empty=%b, required 0 0 1", rx_read_ack, level, empty);
    end
    @(negedge clk); rst = 1'b0;
    wait_ack(1'b1, "recapture_rise");
    model_accept(8'h3C);
    rx_data_ready = 1'b0;
    wait_ack(1'b0, "recapture_fall");
    pop_byte();
    vectors++;
    if (level !== '0) begin
      miscompares++;
      $display("FAIL recapture_level: level=%0d, required 0", level);
    end
  endtask

`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
  task automatic test_irq();
    for (int i = 0; i < DEPTH / 2; i++) send_byte(8'($urandom_range(0, 255)));
    vectors++;
    if (irq_thresh !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_at_thresh: irq=%b, required 1", irq_thresh);
    end
    pop_byte();
    vectors++;
    if (irq_thresh !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_below: irq=%b, required 0", irq_thresh);
    end
    while (exp_q.size() > 0) pop_byte();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_ovr_clr();
    test_full_simul();
    test_underflow_wrap();
    test_random();
    test_reset_in_ack();
`ifdef NEXI_UART_RX_FIFO_THRESH_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nexi_uart_rx_fifo.md
Name: nexi_uart_rx_fifo

Overview:
- Downstream consumer of the minimal UART receiver.
- Takes each completed byte over the receiver's `data`/`data_ready`/`read_ack` four-phase handshake and buffers it in a synchronous FIFO.
- Presents the FIFO to the bus-side master as a first-word-fall-through pop interface.
- Keeps the receiver drained even when the master is slow: bytes that arrive while the FIFO is full are dropped and flagged.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, $clog2(DEPTH), pointer width; derived, do not override.
- THRESH, DEPTH/2, level at or above which `irq_thresh` asserts (optional feature only).

Ports:
- clk  in  1  system clock; the receiver may run on another clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from receiver; stable while `rx_data_ready` is high.
- rx_data_ready  in  1  receiver byte-valid level; asynchronous to clk.
- rx_read_ack  out  1  acknowledge level back to receiver.
- rd_en  in  1  pop request from master.
- rd_data  out  8  head of FIFO; valid when `empty`=0.
- empty  out  1  FIFO holds no data.
- full  out  1  FIFO holds DEPTH entries.
- level  out  AW+1  current entry count.
- overrun  out  1  sticky: at least one byte was dropped.
- ovr_clr  in  1  clears `overrun`.
- irq_thresh  out  1  optional; only with the macro defined.

Behaviour:
- Reset (async assert, sync release): all pointers/counters 0; `rx_read_ack`=0; `empty`=1; `full`=0; `level`=0; `overrun`=0; sync flops 0; handshake FSM in IDLE.
- `rx_data_ready` passes through a 2-flop synchronizer to form `rdy_s`.
- Handshake FSM, two states:
  - IDLE: when `rdy_s`=1, capture `rx_data` and set `rx_read_ack`<=1, go to ACK.
    - If FIFO not full (after accounting for a same-cycle pop): push the byte.
    - If FIFO full: drop the byte, set `overrun`<=1.
  - ACK: hold `rx_read_ack`=1 until `rdy_s`=0, then `rx_read_ack`<=0, go to IDLE.
  - Exactly one push per handshake; a level held high never causes double pushes.
- Push latency: `empty` falls 3 clk edges after `rx_data_ready` rises (2 sync + 1 push).
- Pop:
  - `rd_en` with `empty`=0 advances the read pointer; `rd_data` shows the next entry on the following cycle.
  - `rd_en` with `empty`=1 is ignored; pointers and `level` unchanged.
- Simultaneous push and pop:
  - When full: both occur; `level` stays DEPTH; no overrun.
  - When empty: only the push occurs.
- Pointers are AW bits and wrap modulo DEPTH.
- `level` increments on push-only, decrements on pop-only, and is otherwise unchanged.
- `full` = (`level`==DEPTH); `empty` = (`level`==0); both registered, consistent with `level`.
- `overrun` is set by a dropped byte and cleared by `ovr_clr`. If set and clear coincide, set wins.
- `rd_data` = mem[rptr] (combinational read of the registered array). It is don't-care while `empty`=1.
- Reset mid-handshake drops `rx_read_ack` immediately. The receiver's `data_ready` may still be high; after release, the FSM re-captures the byte. This duplicate is accepted behaviour.

Optional Feature:
- Macro: NEXI_UART_RX_FIFO_THRESH_IRQ_EN.
- Defined: port `irq_thresh` exists, registered, equal to (`level` >= THRESH); reset value 0.
- Undefined: port and logic absent; THRESH unused.

Decomposition:
- Package `nexi_uart_pkg` holds:
  - byte width constant UART_DW=8;
  - FSM state encoding (ST_IDLE, ST_ACK);
  - default DEPTH constant.
- One sub-module, `nexi_sync_2ff`: generic 2-flop synchronizer with async active-high reset. It is reused for `rx_data_ready` here and reusable elsewhere.
- FIFO storage and pointers stay inline.

Test Plan:
- Single byte: drive `rx_data`=8'hA5, raise `rx_data_ready` → `rx_read_ack` high 3 edges later. Drop ready → ack low 3 edges after. `empty`=0, `rd_data`=8'hA5; pop → `empty`=1.
- Fill: 16 handshakes with bytes 0x00..0x0F (DEPTH=16) → `full`=1, `level`=16. 17th byte 0xFF still acked, `overrun`=1, pops return 0x00..0x0F in order.
- Overrun clear: pulse `ovr_clr` → `overrun`=0. Same cycle as a dropped byte → `overrun` stays 1.
- Full plus simultaneous: when full, pop on the exact push cycle → no overrun, `level` stays 16, new byte appears last.
- Underflow and wrap: `rd_en` on empty → `level` stays 0. Then 40 push/pop pairs → order preserved across pointer wrap.
- Reset in ACK: assert `rst` while `rx_read_ack`=1 → ack 0 same cycle, `level`=0. With the macro: `level` 8 → `irq_thresh`=1, `level` 7 → 0.
